// File: rtl/cpu_pkg.sv
// Shared constants and the rx state encoding for the CPU I/O port controller.
package cpu_pkg;

  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned WD_WIDTH      = 8;
  localparam int unsigned STALL_TIMEOUT = 255;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous transmit FIFO; head is the registered entry at the read pointer.
module io_tx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// Device side of the CPU in/out port pair: tx FIFO, one-word rx holding
// register, CPU stall generation and stuck-handshake watchdogs.
module io_port_controller
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   out_wr,
  input  logic [WIDTH-1:0]       OutPort_data,
  input  logic                   in_rd,
  output logic [WIDTH-1:0]       inPort_input,
  output logic                   cpu_stall,
  output logic [WIDTH-1:0]       ext_out_data,
  output logic                   ext_out_valid,
  input  logic                   ext_out_ready,
  input  logic [WIDTH-1:0]       ext_in_data,
  input  logic                   ext_in_valid,
  output logic                   ext_in_ready,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   overflow_err
);

  rx_state_t            rx_state;
  rx_state_t            rx_next;
  logic [WIDTH-1:0]     rx_hold;
  logic                 load_hold;
  logic                 load_in;

  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;
  logic                 tx_push;
  logic                 out_block;
  logic                 in_block;

  logic [WD_WIDTH-1:0]  in_wd;
  logic [WD_WIDTH-1:0]  out_wd;
  logic                 in_stuck;
  logic                 out_stuck;

  // Handshake and stall decode.
  always_comb begin
    tx_pop    = ext_out_valid && ext_out_ready;
    out_block = out_wr && tx_full && !tx_pop;
    in_block  = in_rd && (rx_state == RX_EMPTY);
    cpu_stall = out_block || in_block;
    tx_push   = out_wr && !cpu_stall;
    in_stuck  = ext_in_valid && !ext_in_ready;
    out_stuck = out_wr && cpu_stall;
  end

  assign ext_out_valid = !tx_empty;

  io_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (tx_push),
    .pop     (tx_pop),
    .wr_data (OutPort_data),
    .head    (ext_out_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (out_count)
  );

  // RX state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_state <= RX_EMPTY;
    end else begin
      rx_state <= rx_next;
    end
  end

  // RX next state, producer ready and datapath load enables.
  always_comb begin
    rx_next      = rx_state;
    ext_in_ready = 1'b1;
    load_hold    = 1'b0;
    load_in      = 1'b0;
    unique case (rx_state)
      RX_EMPTY: begin
        if (ext_in_valid) begin
          load_hold = 1'b1;
          rx_next   = RX_FULL;
        end
      end
      RX_FULL: begin
        ext_in_ready = in_rd;
        if (in_rd) begin
          load_in = 1'b1;
          if (ext_in_valid) begin
            load_hold = 1'b1;
          end else begin
            rx_next = RX_EMPTY;
          end
        end
      end
      default: rx_next = RX_EMPTY;
    endcase
  end

  // RX holding register and the word presented to the CPU.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_hold      <= '0;
      inPort_input <= '0;
    end else begin
      if (load_in) begin
        inPort_input <= rx_hold;
      end
      if (load_hold) begin
        rx_hold <= ext_in_data;
      end
    end
  end

  // Watchdogs: a condition held on 256 consecutive edges sets the sticky error.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      in_wd        <= '0;
      out_wd       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (in_stuck) begin
        if (in_wd != WD_WIDTH'(STALL_TIMEOUT)) begin
          in_wd <= in_wd + WD_WIDTH'(1);
        end
      end else begin
        in_wd <= '0;
      end
      if (out_stuck) begin
        if (out_wd != WD_WIDTH'(STALL_TIMEOUT)) begin
          out_wd <= out_wd + WD_WIDTH'(1);
        end
      end else begin
        out_wd <= '0;
      end
      if ((in_stuck && (in_wd == WD_WIDTH'(STALL_TIMEOUT))) ||
          (out_stuck && (out_wd == WD_WIDTH'(STALL_TIMEOUT)))) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Bench for io_port_controller: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_io_port_controller;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic                   Clock;
  logic                   Reset;
  logic                   out_wr;
  logic [WIDTH-1:0]       OutPort_data;
  logic                   in_rd;
  logic [WIDTH-1:0]       inPort_input;
  logic                   cpu_stall;
  logic [WIDTH-1:0]       ext_out_data;
  logic                   ext_out_valid;
  logic                   ext_out_ready;
  logic [WIDTH-1:0]       ext_in_data;
  logic                   ext_in_valid;
  logic                   ext_in_ready;
  logic [$clog2(DEPTH):0] out_count;
  logic                   overflow_err;

  io_port_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .out_wr        (out_wr),
    .OutPort_data  (OutPort_data),
    .in_rd         (in_rd),
    .inPort_input  (inPort_input),
    .cpu_stall     (cpu_stall),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .out_count     (out_count),
    .overflow_err  (overflow_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] m_q[$];
  bit          m_rx_full;
  logic [31:0] m_hold;
  logic [31:0] m_inp;
  bit          m_ovf;
  int          m_run_in;
  int          m_run_out;

  // Pre-edge samples of the combinational outputs from the latest step.
  logic s_stall;
  logic s_irdy;

  typedef struct {
    logic        ow;
    logic [31:0] od;
    logic        rd;
    logic        ordy;
    logic [31:0] id;
    logic        iv;
    logic        e_stall;
    logic        e_irdy;
    int          e_cnt;
    logic        e_vld;
    logic [31:0] e_head;
    logic [31:0] e_inp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ow, logic [31:0] od, logic rd, logic ordy,
                              logic [31:0] id, logic iv, logic e_stall, logic e_irdy,
                              int e_cnt, logic e_vld, logic [31:0] e_head,
                              logic [31:0] e_inp);
    vec_t v;
    v.ow = ow; v.od = od; v.rd = rd; v.ordy = ordy; v.id = id; v.iv = iv;
    v.e_stall = e_stall; v.e_irdy = e_irdy; v.e_cnt = e_cnt; v.e_vld = e_vld;
    v.e_head = e_head; v.e_inp = e_inp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rx_full = 1'b0;
    m_hold    = '0;
    m_inp     = '0;
    m_ovf     = 1'b0;
    m_run_in  = 0;
    m_run_out = 0;
  endtask

  // One clock: drive, compare combinational outputs, clock, advance model, compare state.
  task automatic step(input logic ow, input logic [31:0] od, input logic rd,
                      input logic ordy, input logic [31:0] id, input logic iv);
    bit pop, full, e_stall, e_irdy;
    out_wr = ow; OutPort_data = od; in_rd = rd;
    ext_out_ready = ordy; ext_in_data = id; ext_in_valid = iv;
    #2;
    pop     = (m_q.size() > 0) && ordy;
    full    = (m_q.size() == DEPTH);
    e_stall = (ow && full && !pop) || (rd && !m_rx_full);
    e_irdy  = !m_rx_full || rd;
    s_stall = cpu_stall;
    s_irdy  = ext_in_ready;
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("ext_in_ready", 32'(ext_in_ready), 32'(e_irdy));
    @(posedge Clock);
    if (pop) void'(m_q.pop_front());
    if (ow && !e_stall) m_q.push_back(od);
    if (!m_rx_full) begin
      if (iv) begin m_hold = id; m_rx_full = 1'b1; end
    end else if (rd) begin
      m_inp = m_hold;
      if (iv) m_hold = id; else m_rx_full = 1'b0;
    end
    m_run_in  = (iv && !e_irdy) ? m_run_in + 1 : 0;
    m_run_out = (ow && e_stall) ? m_run_out + 1 : 0;
    if (m_run_in >= 256 || m_run_out >= 256) m_ovf = 1'b1;
    #1;
    chk("out_count", 32'(out_count), 32'(m_q.size()));
    chk("ext_out_valid", 32'(ext_out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("ext_out_data", ext_out_data, m_q[0]);
    chk("inPort_input", inPort_input, m_inp);
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  // Reset for two edges with traffic on every input, then check the reset state.
  task automatic do_reset();
    Reset = 1'b1;
    out_wr = 1'b1; OutPort_data = 32'hDEAD_BEEF; in_rd = 1'b1;
    ext_out_ready = 1'b1; ext_in_data = 32'h1234_5678; ext_in_valid = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    out_wr = 1'b0; in_rd = 1'b0; ext_out_ready = 1'b0; ext_in_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_ext_out_valid", 32'(ext_out_valid), 32'd0);
    chk("rst_ext_out_data", ext_out_data, 32'd0);
    chk("rst_inPort_input", inPort_input, 32'd0);
    chk("rst_ext_in_ready", 32'(ext_in_ready), 32'd1);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_overflow_err", 32'(overflow_err), 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    out_wr = 1'b0; OutPort_data = '0; in_rd = 1'b0;
    ext_out_ready = 1'b0; ext_in_data = '0; ext_in_valid = 1'b0;
    @(posedge Clock);
    #1;
    do_reset();

    //      ow  od     rd ordy id     iv  stall irdy cnt vld head   inp
    tbl.push_back(mk(1, 32'h66, 0, 0, 32'h0, 0, 0, 1, 1, 1, 32'h66, 32'h0));
    tbl.push_back(mk(1, 32'hCD, 0, 0, 32'h0, 0, 0, 1, 2, 1, 32'h66, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'h0, 0, 0, 1, 1, 1, 32'hCD, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'h0, 0, 0, 1, 0, 0, 32'h0,  32'h0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1, 32'(i), 0, 0, 32'h0, 0, 0, 1, i, 1, 32'h1, 32'h0));
    tbl.push_back(mk(1, 32'h5,  0, 0, 32'h0, 0, 1, 1, 4, 1, 32'h1,  32'h0));
    tbl.push_back(mk(1, 32'h5,  0, 1, 32'h0, 0, 0, 1, 4, 1, 32'h2,  32'h0));
    for (int i = 6; i <= 13; i++)
      tbl.push_back(mk(1, 32'(i), 0, 1, 32'h0, 0, 0, 1, 4, 1, 32'(i - 3), 32'h0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 32'h0, 0, 1, 32'h0, 0, 0, 1, 3 - i, 1, 32'(11 + i), 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'h0,  0, 0, 1, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h56, 1, 0, 1, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0, 32'h56));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 1, 1, 0, 0, 32'h0, 32'h56));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 1, 1, 0, 0, 32'h0, 32'h56));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h34, 1, 1, 1, 0, 0, 32'h0, 32'h56));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0, 32'h56));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h91, 1, 0, 1, 0, 0, 32'h0, 32'h34));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0, 32'h91));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0, 32'h91));

    foreach (tbl[k]) begin
      step(tbl[k].ow, tbl[k].od, tbl[k].rd, tbl[k].ordy, tbl[k].id, tbl[k].iv);
      chk($sformatf("tbl%0d_stall", k), 32'(s_stall), 32'(tbl[k].e_stall));
      chk($sformatf("tbl%0d_irdy", k), 32'(s_irdy), 32'(tbl[k].e_irdy));
      chk($sformatf("tbl%0d_count", k), 32'(out_count), 32'(tbl[k].e_cnt));
      chk($sformatf("tbl%0d_valid", k), 32'(ext_out_valid), 32'(tbl[k].e_vld));
      if (tbl[k].e_vld) chk($sformatf("tbl%0d_head", k), ext_out_data, tbl[k].e_head);
      chk($sformatf("tbl%0d_inport", k), inPort_input, tbl[k].e_inp);
    end

    // RX watchdog: producer held off while FULL and the CPU never reads.
    do_reset();
    step(0, 0, 0, 0, 32'hA5A5_0001, 1);
    repeat (255) step(0, 0, 0, 0, 32'hA5A5_0002, 1);
    chk("wd_in_255", 32'(overflow_err), 32'd0);
    step(0, 0, 0, 0, 32'hA5A5_0002, 1);
    chk("wd_in_256", 32'(overflow_err), 32'd1);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    chk("wd_in_sticky", 32'(overflow_err), 32'd1);

    // Reset in the middle of traffic with FIFO loaded and rx FULL.
    step(1, 32'h77, 0, 0, 0, 0);
    step(1, 32'h78, 0, 0, 0, 0);
    do_reset();

    // TX watchdog: out_wr held against a full FIFO that never drains.
    for (int i = 0; i < 4; i++) step(1, 32'(100 + i), 0, 0, 0, 0);
    repeat (255) step(1, 32'hBB, 0, 0, 0, 0);
    chk("wd_out_255", 32'(overflow_err), 32'd0);
    step(1, 32'hBB, 0, 0, 0, 0);
    chk("wd_out_256", 32'(overflow_err), 32'd1);
    chk("wd_out_fifo_kept", ext_out_data, 32'd100);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) != 0),
           $urandom,
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
